// File: rtl/analysis_driver.sv
// ============================================================================
//  Module      : analysis_driver
//  Description : Steers an external analysis FSM into a requested state by
//                driving its a/b inputs, while tracking that FSM in a local
//                shadow copy. Optional output-consistency checker compares
//                the FSM's Mealy output with the shadow prediction.
//  Config      : define ANALYSIS_DRIVER_CHECK_EN to enable the sticky
//                mismatch checker (output_y / clear_err are otherwise unused).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module analysis_driver (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic       input_a,
  output logic       input_b,
  input  logic [1:0] output_y,
  output logic       done,
  output logic [1:0] shadow_state,
  output logic       mismatch,
  input  logic       clear_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_shadow;
  logic [1:0] r_target;
  logic [1:0] w_ab;
  logic       w_done;

  // Next state of the analysis FSM for a given state and {a,b} input.
  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [1:0] ab);
    logic [1:0] n;
    n = 2'b00;
    case (s)
      2'b00: n = ab;
      2'b01: n = ab[1] ? 2'b10 : 2'b00;
      2'b10: begin
        case (ab)
          2'b00:   n = 2'b00;
          2'b01:   n = 2'b01;
          2'b10:   n = 2'b10;
          default: n = 2'b01;
        endcase
      end
      default: n = 2'b01;
    endcase
    return n;
  endfunction

  // Mealy output of the analysis FSM for a given state and {a,b} input.
  function automatic logic [1:0] fsm_y(input logic [1:0] s, input logic [1:0] ab);
    logic [1:0] y;
    y = 2'b00;
    case (s)
      2'b00, 2'b01: begin
        case (ab)
          2'b00:   y = 2'b00;
          2'b01:   y = 2'b01;
          default: y = 2'b10;
        endcase
      end
      2'b10: begin
        case (ab)
          2'b00:   y = 2'b00;
          2'b01:   y = 2'b01;
          2'b10:   y = 2'b10;
          default: y = 2'b01;
        endcase
      end
      default: y = 2'b01;
    endcase
    return y;
  endfunction

  // Lowest-encoded input that reaches the target in one step; 00 if none
  // does, which always lands on 00 or 01 from where the target is one hop.
  function automatic logic [1:0] hop(input logic [1:0] s, input logic [1:0] t);
    logic [1:0] h;
    h = 2'b00;
    if      (fsm_next(s, 2'b00) == t) h = 2'b00;
    else if (fsm_next(s, 2'b01) == t) h = 2'b01;
    else if (fsm_next(s, 2'b10) == t) h = 2'b10;
    else if (fsm_next(s, 2'b11) == t) h = 2'b11;
    return h;
  endfunction

  // Drive selection and completion detect, purely from control state,
  // shadow and captured target.
  always_comb begin
    w_ab   = 2'b00;
    w_done = 1'b0;
    if (r_state == STEP) begin
      if (r_shadow == r_target) begin
        w_done = 1'b1;
      end else begin
        w_ab = hop(r_shadow, r_target);
      end
    end
  end

  // Control FSM plus shadow tracking of the driven analysis FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_shadow <= 2'b00;
      r_target <= 2'b00;
    end else begin
      r_shadow <= fsm_next(r_shadow, w_ab);
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_target <= req_target;
            r_state  <= STEP;
          end
        end
        STEP: begin
          if (w_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign input_a      = w_ab[1];
  assign input_b      = w_ab[0];
  assign done         = w_done;
  assign shadow_state = r_shadow;

`ifdef ANALYSIS_DRIVER_CHECK_EN
  logic       r_mismatch;
  logic [1:0] w_exp_y;

  assign w_exp_y = fsm_y(r_shadow, w_ab);

  // Sticky error: a disagreeing output sets it, and setting wins over clearing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mismatch <= 1'b0;
    end else if (output_y != w_exp_y) begin
      r_mismatch <= 1'b1;
    end else if (clear_err) begin
      r_mismatch <= 1'b0;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused;

  assign w_unused = ^{output_y, clear_err, fsm_y(r_shadow, w_ab)};
  assign mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/analysis_driver.md
ANALYSIS_DRIVER -- requirements
Module: analysis_driver

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req_valid  in  1  steer request strobe.
REQ-004 SHALL have ports: req_target  in  2  requested state of the driven analysis FSM.
REQ-005 SHALL have ports: req_ready  out  1  high when a request can be accepted.
REQ-006 SHALL have ports: input_a / input_b  out  1 each  drive to the analysis FSM.
REQ-007 SHALL have ports: output_y  in  2  Mealy output returned by the analysis FSM.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse, FSM currently in target.
REQ-009 SHALL have ports: shadow_state  out  2  tracked FSM state; mismatch  out  1  sticky error; clear_err  in  1  clears mismatch.

Function
REQ-010 SHALL keep a shadow of the analysis FSM, updated every rising edge as shadow <= next(shadow, {input_a,input_b}), using the table below (entries are ab:next/y).
REQ-011 SHALL use this table: S00: 00:00/00, 01:01/01, 10:10/10, 11:11/10.
REQ-012 SHALL use this table: S01: 00:00/00, 01:00/01, 10:10/10, 11:10/10.
REQ-013 SHALL use this table: S10: 00:00/00, 01:01/01, 10:10/10, 11:01/01; S11: all ab -> 01/01.
REQ-014 SHALL implement control states IDLE and STEP; req_ready = (state==IDLE).
REQ-015 SHALL, in IDLE, drive ab=00; on req_valid&&req_ready, capture req_target and enter STEP at that edge.
REQ-016 SHALL, in STEP with shadow==target, assert done combinationally for that cycle, drive ab=00 and return to IDLE.
REQ-017 SHALL, in STEP with shadow!=target, drive ab=hop(shadow,target) and remain in STEP.
REQ-018 SHALL define hop as the lowest-encoded ab reaching target in one step, else 00; at most two hops per request.
REQ-019 SHALL ignore req_valid while in STEP, without queuing.
REQ-020 SHALL keep input_a/input_b combinational from the control state, shadow and target; no other output latency applies.

Reset
REQ-021 SHALL, on reset low, immediately force IDLE, shadow_state=00, target=00, done=0, mismatch=0 and ab=00, including mid-STEP.
REQ-022 SHALL resume on the first rising edge after reset deasserts; the integrator releases the analysis FSM reset in the same cycle.

Configuration
REQ-023 SHALL, with ANALYSIS_DRIVER_CHECK_EN defined, compare output_y each cycle with the table y for (shadow, ab), and set mismatch at the edge on inequality.
REQ-024 SHALL, with ANALYSIS_DRIVER_CHECK_EN defined, clear mismatch on a clear_err edge, with set taking priority over clear in the same cycle.
REQ-025 SHALL, without ANALYSIS_DRIVER_CHECK_EN, tie mismatch to 0 and ignore output_y and clear_err; all other behaviour is identical.

Verification
REQ-026 SHALL cover: after reset, req T=11 in cycle0 -> cycle1 ab=11 -> cycle2 done=1, shadow_state=11 -> cycle3 shadow_state=01, req_ready=1.
REQ-027 SHALL cover: shadow 00, req T=00 -> next cycle done=1 with zero hops, ab held 00 throughout.
REQ-028 SHALL cover: shadow 11, req T=10 -> accept edge moves shadow to 01 -> ab=10 -> done with shadow_state=10.
REQ-029 SHALL cover: req_valid pulsed during STEP -> req_ready=0, request dropped, original target completes.
REQ-030 SHALL cover: CHECK_EN, force output_y=11 while expected 00 -> mismatch=1 after edge, held until clear_err -> 0.
REQ-031 SHALL cover: reset low mid-STEP -> done=0, ab=00, shadow_state=00, req_ready=1 without a clock edge.
